// File: rtl/pc_sequencer_pkg.sv
//============================================================================
// pc_seq_pkg : shared types and constants for the PC sequencer block
// Revision   : 1.0
//============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [2:0] {
    OP_SEQ   = 3'd0,
    OP_BRN   = 3'd1,
    OP_BRC   = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4,
    OP_RETIE = 3'd5,
    OP_RETID = 3'd6
  } op_class_t;

  typedef enum logic [1:0] {
    PC_SRC_IR    = 2'd0,
    PC_SRC_STACK = 2'd1,
    PC_SRC_INTV  = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  localparam logic [9:0] INT_VEC = 10'h3FF;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_sp_ctrl.sv
//============================================================================
// sp_ctrl : call/return stack pointer with sticky overflow/underflow flag
// Revision: 1.0
//============================================================================
`default_nettype none

module sp_ctrl #(
  parameter int SP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  output logic [SP_W-1:0] o_sp_addr,
  output logic            o_stk_err
);

  logic [SP_W-1:0] r_sp;
  logic            r_stk_err;
  logic [SP_W-1:0] w_sp_dec;
  logic [SP_W-1:0] w_sp_inc;
  logic            w_full;
  logic            w_empty;

  assign w_sp_dec = r_sp - SP_W'(1);
  assign w_sp_inc = r_sp + SP_W'(1);
  assign w_full   = (r_sp == SP_W'(1));
  assign w_empty  = (r_sp == '0);

  // Push writes below the current top; otherwise the address tracks SP.
  assign o_sp_addr = i_push ? w_sp_dec : r_sp;
  assign o_stk_err = r_stk_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else if (i_push) begin
      r_sp <= w_sp_dec;
      if (w_full) r_stk_err <= 1'b1;
    end else if (i_pop) begin
      r_sp <= w_sp_inc;
      if (w_empty) r_stk_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//============================================================================
// pc_sequencer : fetch/execute FSM driving PC strobes, stack and interrupts
// Revision     : 1.0
//============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int SP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      i_op_class,
  input  logic            i_cond_met,
  input  logic            i_int_req,
  output logic            o_pc_rst,
  output logic            o_pc_ld,
  output logic            o_pc_inc,
  output logic [1:0]      o_pc_mux_sel,
  output logic [SP_W-1:0] o_sp_addr,
  output logic            o_scr_we,
  output logic            o_i_en,
  output logic            o_flg_shad_ld,
  output logic            o_flg_restore,
  output logic            o_stk_err
);

  state_t  r_state;
  logic    r_i_en;

  logic    w_pc_ld;
  logic    w_push;
  logic    w_pop;
  logic    w_restore;
  pc_src_t w_sel;

  always_comb begin
    w_pc_ld   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_restore = 1'b0;
    w_sel     = PC_SRC_IR;
    case (r_state)
      ST_EXEC: begin
        case (i_op_class)
          OP_BRN:  w_pc_ld = 1'b1;
          OP_BRC:  w_pc_ld = i_cond_met;
          OP_CALL: begin
            w_push  = 1'b1;
            w_pc_ld = 1'b1;
          end
          OP_RET, OP_RETIE, OP_RETID: begin
            w_pop     = 1'b1;
            w_pc_ld   = 1'b1;
            w_sel     = PC_SRC_STACK;
            w_restore = (i_op_class != OP_RET);
          end
          default: ;
        endcase
      end
      ST_INTR: begin
        w_push  = 1'b1;
        w_pc_ld = 1'b1;
        w_sel   = PC_SRC_INTV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_i_en  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (i_op_class == OP_RETIE) r_i_en <= 1'b1;
          if (i_op_class == OP_RETID) r_i_en <= 1'b0;
          // Uses the pre-update enable so RETIE defers any interrupt by one instruction.
          r_state <= (i_int_req && r_i_en) ? ST_INTR : ST_FETCH;
        end
        ST_INTR: begin
          r_i_en  <= 1'b0;
          r_state <= ST_FETCH;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  sp_ctrl #(
    .SP_W (SP_W)
  ) u_sp (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .o_sp_addr (o_sp_addr),
    .o_stk_err (o_stk_err)
  );

  // Masked while reset is held so the strobe appears only after release.
  assign o_pc_rst      = (r_state == ST_INIT) && rst_n;
  assign o_pc_inc      = (r_state == ST_FETCH);
  assign o_pc_ld       = w_pc_ld;
  assign o_pc_mux_sel  = w_sel;
  assign o_scr_we      = w_push;
  assign o_i_en        = r_i_en;
  assign o_flg_shad_ld = (r_state == ST_INTR);
  assign o_flg_restore = w_restore;

endmodule

`default_nettype wire
